// File: rtl/blastn_ungapped_extender.sv
// Ungapped X-drop seed extender: extends a Blastn seed hit right, then left, and
// reports the best-scoring span as an HSP record when it clears THRESHOLD.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a seed; seed_ready high
// S_R_FETCH | drive right-phase pointers with mem_rd
// S_R_CMP   | score right-phase characters, advance pointers upward
// S_L_INIT  | reload running from best, set left pointers to seed-1
// S_L_FETCH | drive left-phase pointers with mem_rd
// S_L_CMP   | score left-phase characters, advance pointers downward
// S_REPORT  | HSP record held on hsp_* until hsp_ready
module blastn_ungapped_extender #(
  parameter int LENGTH_CHAR    = 3,
  parameter int LENGTH_COUNTER = 8,
  parameter int LENGTH_SCORE   = 8,
  parameter int SEED_LEN       = 4,
  parameter int MATCH          = 1,
  parameter int MISMATCH       = 3,
  parameter int X_DROP         = 6,
  parameter int THRESHOLD      = 10
) (
  input  logic                      array_clk,
  input  logic                      reset,
  input  logic                      seed_valid,
  output logic                      seed_ready,
  input  logic [LENGTH_COUNTER-1:0] seed_q_addr,
  input  logic [LENGTH_COUNTER-1:0] seed_s_addr,
  input  logic [LENGTH_COUNTER-1:0] q_len,
  input  logic [LENGTH_COUNTER-1:0] s_len,
  output logic [LENGTH_COUNTER-1:0] Q_address,
  output logic [LENGTH_COUNTER-1:0] S_address,
  output logic                      mem_rd,
  input  logic [LENGTH_CHAR-1:0]    Q_context,
  input  logic [LENGTH_CHAR-1:0]    S_context,
  output logic                      hsp_valid,
  input  logic                      hsp_ready,
  output logic [LENGTH_COUNTER-1:0] hsp_q_addr,
  output logic [LENGTH_COUNTER-1:0] hsp_s_addr,
  output logic [LENGTH_COUNTER-1:0] hsp_length,
  output logic [LENGTH_SCORE-1:0]   hsp_score,
  output logic                      busy
);

  localparam int LC = LENGTH_COUNTER;
  localparam int SW = LENGTH_SCORE + 2;

  localparam logic signed [SW-1:0] C_SEED_SCORE = SW'(SEED_LEN * MATCH);
  localparam logic signed [SW-1:0] C_MATCH      = SW'(MATCH);
  localparam logic signed [SW-1:0] C_MISMATCH   = SW'(MISMATCH);
  localparam logic signed [SW-1:0] C_XDROP      = SW'(X_DROP);
  localparam logic signed [SW-1:0] C_THRESH     = SW'(THRESHOLD);
  localparam logic signed [SW-1:0] C_SCORE_MAX  = SW'((1 << LENGTH_SCORE) - 1);
  localparam logic [LC-1:0]        C_NO_ADDR    = '1;
  localparam logic [LC:0]          C_SEED_LEN_X = (LC+1)'(SEED_LEN);
  localparam logic [LENGTH_CHAR-1:0] C_CHAR_N   = LENGTH_CHAR'(5);

  typedef enum logic [2:0] {
    S_IDLE,
    S_R_FETCH,
    S_R_CMP,
    S_L_INIT,
    S_L_FETCH,
    S_L_CMP,
    S_REPORT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [LC-1:0]          r_seed_q;
  logic [LC-1:0]          r_seed_s;
  logic [LC-1:0]          r_q_len;
  logic [LC-1:0]          r_s_len;
  logic [LC-1:0]          r_q_ptr;
  logic [LC-1:0]          r_s_ptr;
  logic [LC-1:0]          r_steps;
  logic [LC-1:0]          r_r_ext;
  logic [LC-1:0]          r_l_ext;
  logic signed [SW-1:0]   r_running;
  logic signed [SW-1:0]   r_best;
  logic [LC-1:0]          r_hsp_q;
  logic [LC-1:0]          r_hsp_s;
  logic [LC-1:0]          r_hsp_len;
  logic [LENGTH_SCORE-1:0] r_hsp_score;

  logic                   w_accept;
  logic [LC:0]            w_q_end;
  logic [LC:0]            w_s_end;
  logic                   w_r_skip;
  logic                   w_l_skip;
  logic                   w_match;
  logic signed [SW-1:0]   w_run_step;
  logic                   w_improve;
  logic signed [SW-1:0]   w_best_step;
  logic [LC-1:0]          w_steps_inc;
  logic [LC-1:0]          w_q_ptr_inc;
  logic [LC-1:0]          w_s_ptr_inc;
  logic                   w_xdrop;
  logic                   w_r_stop;
  logic                   w_l_stop;
  logic signed [SW-1:0]   w_fin_best;
  logic [LC-1:0]          w_fin_l_ext;
  logic                   w_pass;

  assign seed_ready = (r_state == S_IDLE) && !reset;
  assign busy       = (r_state != S_IDLE);
  assign mem_rd     = (r_state == S_R_FETCH) || (r_state == S_L_FETCH);
  assign Q_address  = mem_rd ? r_q_ptr : C_NO_ADDR;
  assign S_address  = mem_rd ? r_s_ptr : C_NO_ADDR;
  assign hsp_valid  = (r_state == S_REPORT);
  assign hsp_q_addr = r_hsp_q;
  assign hsp_s_addr = r_hsp_s;
  assign hsp_length = r_hsp_len;
  assign hsp_score  = r_hsp_score;

  assign w_accept = seed_valid && seed_ready;

  // Widened by one bit so seeds near the top of the address space cannot wrap.
  assign w_q_end  = {1'b0, seed_q_addr} + C_SEED_LEN_X;
  assign w_s_end  = {1'b0, seed_s_addr} + C_SEED_LEN_X;
  assign w_r_skip = (w_q_end >= {1'b0, q_len}) || (w_s_end >= {1'b0, s_len});
  assign w_l_skip = (r_seed_q == '0) || (r_seed_s == '0);

  // N and "no data" never score as a match, even when both sides agree.
  assign w_match     = (Q_context == S_context) && (Q_context != '0) && (Q_context != C_CHAR_N);
  assign w_run_step  = w_match ? (r_running + C_MATCH) : (r_running - C_MISMATCH);
  assign w_improve   = (w_run_step > r_best);
  assign w_best_step = w_improve ? w_run_step : r_best;
  assign w_steps_inc = r_steps + LC'(1);
  assign w_q_ptr_inc = r_q_ptr + LC'(1);
  assign w_s_ptr_inc = r_s_ptr + LC'(1);
  assign w_xdrop     = ((w_best_step - w_run_step) >= C_XDROP);
  assign w_r_stop    = w_xdrop || (w_q_ptr_inc == r_q_len) || (w_s_ptr_inc == r_s_len);
  assign w_l_stop    = w_xdrop || (r_q_ptr == '0) || (r_s_ptr == '0);

  // Final best and left extension must include the step being scored this cycle.
  assign w_fin_best  = (r_state == S_L_CMP) ? w_best_step : r_best;
  assign w_fin_l_ext = ((r_state == S_L_CMP) && w_improve) ? w_steps_inc : r_l_ext;
  assign w_pass      = (w_fin_best >= C_THRESH);

  always_ff @(posedge array_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_r_skip ? S_L_INIT : S_R_FETCH;
        end
      end
      S_R_FETCH: w_state_nxt = S_R_CMP;
      S_R_CMP:   w_state_nxt = w_r_stop ? S_L_INIT : S_R_FETCH;
      S_L_INIT: begin
        if (w_l_skip) begin
          w_state_nxt = w_pass ? S_REPORT : S_IDLE;
        end else begin
          w_state_nxt = S_L_FETCH;
        end
      end
      S_L_FETCH: w_state_nxt = S_L_CMP;
      S_L_CMP: begin
        if (w_l_stop) begin
          w_state_nxt = w_pass ? S_REPORT : S_IDLE;
        end
      end
      S_REPORT: begin
        if (hsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if ((r_state == S_L_CMP) && !w_l_stop) begin
      w_state_nxt = S_L_FETCH;
    end
  end

  always_ff @(posedge array_clk or posedge reset) begin
    if (reset) begin
      r_seed_q    <= '0;
      r_seed_s    <= '0;
      r_q_len     <= '0;
      r_s_len     <= '0;
      r_q_ptr     <= '0;
      r_s_ptr     <= '0;
      r_steps     <= '0;
      r_r_ext     <= '0;
      r_l_ext     <= '0;
      r_running   <= '0;
      r_best      <= '0;
      r_hsp_q     <= '0;
      r_hsp_s     <= '0;
      r_hsp_len   <= '0;
      r_hsp_score <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_seed_q  <= seed_q_addr;
            r_seed_s  <= seed_s_addr;
            r_q_len   <= q_len;
            r_s_len   <= s_len;
            r_q_ptr   <= w_q_end[LC-1:0];
            r_s_ptr   <= w_s_end[LC-1:0];
            r_steps   <= '0;
            r_r_ext   <= '0;
            r_l_ext   <= '0;
            r_running <= C_SEED_SCORE;
            r_best    <= C_SEED_SCORE;
          end
        end
        S_R_CMP: begin
          r_running <= w_run_step;
          r_best    <= w_best_step;
          r_steps   <= w_steps_inc;
          r_q_ptr   <= w_q_ptr_inc;
          r_s_ptr   <= w_s_ptr_inc;
          if (w_improve) begin
            r_r_ext <= w_steps_inc;
          end
        end
        S_L_INIT: begin
          r_running <= r_best;
          r_steps   <= '0;
          r_q_ptr   <= r_seed_q - LC'(1);
          r_s_ptr   <= r_seed_s - LC'(1);
        end
        S_L_CMP: begin
          r_running <= w_run_step;
          r_best    <= w_best_step;
          r_steps   <= w_steps_inc;
          r_q_ptr   <= r_q_ptr - LC'(1);
          r_s_ptr   <= r_s_ptr - LC'(1);
          if (w_improve) begin
            r_l_ext <= w_steps_inc;
          end
        end
        default: ;
      endcase

      // The record is frozen on entry to S_REPORT so it stays stable under backpressure.
      if ((r_state != S_REPORT) && (w_state_nxt == S_REPORT)) begin
        r_hsp_q   <= r_seed_q - w_fin_l_ext;
        r_hsp_s   <= r_seed_s - w_fin_l_ext;
        r_hsp_len <= LC'(SEED_LEN) + w_fin_l_ext + r_r_ext;
        if (w_fin_best > C_SCORE_MAX) begin
          r_hsp_score <= '1;
        end else begin
          r_hsp_score <= w_fin_best[LENGTH_SCORE-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_blastn_ungapped_extender.sv
// Directed bench for blastn_ungapped_extender: a sequence memory model answers
// fetches one cycle late; each scenario checks the HSP record against hand values.
module tb_blastn_ungapped_extender;

  logic       array_clk;
  logic       reset;
  logic       seed_valid;
  logic       seed_ready;
  logic [7:0] seed_q_addr;
  logic [7:0] seed_s_addr;
  logic [7:0] q_len;
  logic [7:0] s_len;
  logic [7:0] Q_address;
  logic [7:0] S_address;
  logic       mem_rd;
  logic [2:0] Q_context;
  logic [2:0] S_context;
  logic       hsp_valid;
  logic       hsp_ready;
  logic [7:0] hsp_q_addr;
  logic [7:0] hsp_s_addr;
  logic [7:0] hsp_length;
  logic [7:0] hsp_score;
  logic       busy;

  logic [2:0] q_mem [256];
  logic [2:0] s_mem [256];

  int errors = 0;
  int checks = 0;
  int fetch_cnt = 0;
  int addr_viol = 0;

  blastn_ungapped_extender dut (
    .array_clk   (array_clk),
    .reset       (reset),
    .seed_valid  (seed_valid),
    .seed_ready  (seed_ready),
    .seed_q_addr (seed_q_addr),
    .seed_s_addr (seed_s_addr),
    .q_len       (q_len),
    .s_len       (s_len),
    .Q_address   (Q_address),
    .S_address   (S_address),
    .mem_rd      (mem_rd),
    .Q_context   (Q_context),
    .S_context   (S_context),
    .hsp_valid   (hsp_valid),
    .hsp_ready   (hsp_ready),
    .hsp_q_addr  (hsp_q_addr),
    .hsp_s_addr  (hsp_s_addr),
    .hsp_length  (hsp_length),
    .hsp_score   (hsp_score),
    .busy        (busy)
  );

  initial begin
    array_clk = 1'b0;
    forever #5 array_clk = ~array_clk;
  end

  initial begin
    Q_context = '0;
    S_context = '0;
  end

  always @(posedge array_clk) begin
    if (mem_rd) begin
      Q_context <= q_mem[Q_address];
      S_context <= s_mem[S_address];
    end
  end

  always @(negedge array_clk) begin
    if (mem_rd) begin
      fetch_cnt = fetch_cnt + 1;
      if (Q_address == 8'hFF || S_address == 8'hFF) addr_viol = addr_viol + 1;
    end else if (Q_address != 8'hFF || S_address != 8'hFF) begin
      addr_viol = addr_viol + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge array_clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      q_mem[i] = '0;
      s_mem[i] = '0;
    end
  endtask

  task automatic offer_seed(input int q, input int s, input int ql, input int sl);
    seed_q_addr = 8'(q);
    seed_s_addr = 8'(s);
    q_len       = 8'(ql);
    s_len       = 8'(sl);
    seed_valid  = 1'b1;
    tick();
    seed_valid  = 1'b0;
  endtask

  // Counts cycles after the accept edge until hsp_valid; lat==1 is the cycle right after accept.
  task automatic wait_hsp(output int lat, output bit got);
    lat = 1;
    while (!hsp_valid && lat < 300) begin
      tick();
      lat++;
    end
    got = hsp_valid;
  endtask

  task automatic check_hsp(input string tag, input int q, input int s, input int len, input int sc);
    chk({tag, "_q"},     int'(hsp_q_addr), q);
    chk({tag, "_s"},     int'(hsp_s_addr), s);
    chk({tag, "_len"},   int'(hsp_length), len);
    chk({tag, "_score"}, int'(hsp_score),  sc);
  endtask

  task automatic load_full_match();
    clear_mem();
    for (int i = 0; i < 16; i++) begin
      q_mem[i] = 3'((i % 4) + 1);
      s_mem[i] = 3'((i % 4) + 1);
    end
  endtask

  initial begin
    int  lat;
    int  f0;
    bit  got;
    bit  seen;

    reset       = 1'b1;
    seed_valid  = 1'b0;
    hsp_ready   = 1'b1;
    seed_q_addr = '0;
    seed_s_addr = '0;
    q_len       = '0;
    s_len       = '0;
    clear_mem();
    repeat (3) tick();

    chk("rst_seed_ready", int'(seed_ready), 0);
    chk("rst_busy",       int'(busy), 0);
    chk("rst_mem_rd",     int'(mem_rd), 0);
    chk("rst_Q_address",  int'(Q_address), 255);
    chk("rst_S_address",  int'(S_address), 255);
    chk("rst_hsp_valid",  int'(hsp_valid), 0);
    chk("rst_hsp_fields", int'(hsp_q_addr) + int'(hsp_s_addr) + int'(hsp_length) + int'(hsp_score), 0);
    @(negedge array_clk);
    reset = 1'b0;
    tick();
    chk("post_rst_seed_ready", int'(seed_ready), 1);

    // Full match: 8 right steps + 4 left steps.
    load_full_match();
    offer_seed(4, 4, 16, 16);
    chk("full_busy", int'(busy), 1);
    chk("full_seed_ready", int'(seed_ready), 0);
    wait_hsp(lat, got);
    chk("full_valid", int'(got), 1);
    chk("full_latency", lat, 26);
    check_hsp("full", 0, 0, 16, 16);
    tick();
    chk("full_done_valid", int'(hsp_valid), 0);
    chk("full_done_ready", int'(seed_ready), 1);

    // Discard: running 5,6,3,0 then stop; seed at 0 skips the left phase.
    clear_mem();
    q_mem[4] = 3'd1; s_mem[4] = 3'd1;
    q_mem[5] = 3'd2; s_mem[5] = 3'd2;
    q_mem[6] = 3'd1; s_mem[6] = 3'd2;
    q_mem[7] = 3'd3; s_mem[7] = 3'd4;
    f0 = fetch_cnt;
    offer_seed(0, 0, 16, 16);
    lat  = 1;
    seen = 1'b0;
    while (busy && lat < 300) begin
      if (hsp_valid) seen = 1'b1;
      tick();
      lat++;
    end
    chk("discard_no_hsp", int'(seen), 0);
    chk("discard_cycles", lat, 10);
    chk("discard_fetches", fetch_cnt - f0, 4);
    chk("discard_ready", int'(seed_ready), 1);

    // Left extension: 2 right mismatches, 8 left matches, 2 left mismatches.
    clear_mem();
    q_mem[14] = 3'd1; s_mem[24] = 3'd2;
    q_mem[15] = 3'd1; s_mem[25] = 3'd2;
    for (int k = 2; k <= 9; k++) begin
      q_mem[k]      = 3'((k % 4) + 1);
      s_mem[k + 10] = 3'((k % 4) + 1);
    end
    q_mem[1] = 3'd1; s_mem[11] = 3'd3;
    q_mem[0] = 3'd1; s_mem[10] = 3'd3;
    offer_seed(10, 20, 32, 40);
    wait_hsp(lat, got);
    chk("left_valid", int'(got), 1);
    chk("left_latency", lat, 26);
    check_hsp("left", 2, 12, 12, 12);
    tick();

    // Backpressure: five cycles with hsp_ready low, handshake on the sixth.
    load_full_match();
    hsp_ready = 1'b0;
    offer_seed(4, 4, 16, 16);
    wait_hsp(lat, got);
    chk("bp_valid", int'(got), 1);
    check_hsp("bp_c1", 0, 0, 16, 16);
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk("bp_hold_valid", int'(hsp_valid), 1);
      chk("bp_hold_ready", int'(seed_ready), 0);
      check_hsp("bp_hold", 0, 0, 16, 16);
    end
    tick();
    hsp_ready = 1'b1;
    chk("bp_c6_valid", int'(hsp_valid), 1);
    check_hsp("bp_c6", 0, 0, 16, 16);
    tick();
    chk("bp_after_valid", int'(hsp_valid), 0);
    chk("bp_after_ready", int'(seed_ready), 1);

    // N in both sequences at the first right step must cost a mismatch.
    clear_mem();
    for (int i = 0; i < 20; i++) begin
      q_mem[i] = 3'd1;
      s_mem[i] = 3'd1;
    end
    q_mem[6] = 3'd5;
    s_mem[6] = 3'd5;
    offer_seed(2, 2, 20, 20);
    wait_hsp(lat, got);
    chk("n_valid", int'(got), 1);
    chk("n_latency", lat, 34);
    check_hsp("n", 0, 0, 20, 16);
    tick();

    // Reset in the middle of R_CMP drops the seed.
    load_full_match();
    offer_seed(4, 4, 16, 16);
    lat = 0;
    while (!mem_rd && lat < 20) begin
      tick();
      lat++;
    end
    chk("mid_saw_fetch", int'(mem_rd), 1);
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", int'(seed_ready), 0);
    chk("mid_rst_busy",  int'(busy), 0);
    tick();
    @(negedge array_clk);
    reset = 1'b0;
    tick();
    chk("mid_post_ready", int'(seed_ready), 1);
    chk("mid_post_busy",  int'(busy), 0);
    chk("mid_post_Qaddr", int'(Q_address), 255);
    chk("mid_post_valid", int'(hsp_valid), 0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (hsp_valid) seen = 1'b1;
      tick();
    end
    chk("mid_no_hsp", int'(seen), 0);

    chk("addr_255_rule", addr_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
